// File: rtl/xl_rect_fill_pkg.sv
// Shared definitions for the XL rectangle-fill path:
// FSM state encodings and the frame-buffer address packing.
package xl_rect_fill_pkg;

  localparam int XL_X_BITS = 10;
  localparam int XL_Y_BITS = 10;
  localparam int XL_ADDR_BITS = XL_X_BITS + XL_Y_BITS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_FILL,
    ST_DONE
  } xl_state_e;

  // Frame-buffer address is row-major: {y, x}.
  function automatic logic [XL_ADDR_BITS-1:0] xl_pack_addr(
    input logic [XL_Y_BITS-1:0] y,
    input logic [XL_X_BITS-1:0] x
  );
    return {y, x};
  endfunction

endpackage

// File: rtl/xl_raster_counter.sv
// Bounded 2-D raster counter: walks x from xmin to xmax,
// then wraps x and advances y, until (xmax, ymax).
module xl_raster_counter #(
  parameter int X_BITS = 10,
  parameter int Y_BITS = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [X_BITS-1:0] xmin_i,
  input  logic [X_BITS-1:0] xmax_i,
  input  logic [Y_BITS-1:0] ymin_i,
  input  logic [Y_BITS-1:0] ymax_i,
  output logic [X_BITS-1:0] nxt_x_o,
  output logic [Y_BITS-1:0] nxt_y_o,
  output logic              last_o
);

  logic [X_BITS-1:0] xmin_q, xmax_q, cur_x_q;
  logic [Y_BITS-1:0] ymax_q, cur_y_q;

  // Position following the current one in raster order.
  always_comb begin
    nxt_x_o = cur_x_q + X_BITS'(1);
    nxt_y_o = cur_y_q;
    if (cur_x_q == xmax_q) begin
      nxt_x_o = xmin_q;
      nxt_y_o = cur_y_q + Y_BITS'(1);
    end
  end

  assign last_o = (cur_x_q == xmax_q) && (cur_y_q == ymax_q);

  // Latch bounds on load, advance one pixel per step.
  always_ff @(posedge clk) begin
    if (rst) begin
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymax_q  <= '0;
      cur_x_q <= '0;
      cur_y_q <= '0;
    end else if (load_i) begin
      xmin_q  <= xmin_i;
      xmax_q  <= xmax_i;
      ymax_q  <= ymax_i;
      cur_x_q <= xmin_i;
      cur_y_q <= ymin_i;
    end else if (step_i) begin
      cur_x_q <= nxt_x_o;
      cur_y_q <= nxt_y_o;
    end
  end

endmodule

// File: rtl/xl_rect_fill.sv
// XL rectangle fill: accepts one clipped fill command and
// emits one frame-buffer write per cycle in raster order.
module xl_rect_fill
  import xl_rect_fill_pkg::*;
#(
  parameter int PIXEL_WIDTH = 32,
  parameter int X_BITS      = XL_X_BITS,
  parameter int Y_BITS      = XL_Y_BITS,
  parameter int H_VISIBLE   = 800,
  parameter int V_VISIBLE   = 600,
  parameter int ADDR_WIDTH  = X_BITS + Y_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [X_BITS-1:0]      cmd_x0,
  input  logic [Y_BITS-1:0]      cmd_y0,
  input  logic [X_BITS-1:0]      cmd_x1,
  input  logic [Y_BITS-1:0]      cmd_y1,
  input  logic [PIXEL_WIDTH-1:0] cmd_color,
  output logic                   XL_wr_en,
  output logic [ADDR_WIDTH-1:0]  XL_wr_addr,
  output logic [PIXEL_WIDTH-1:0] XL_wr_data,
  output logic                   busy,
  output logic                   done
);

  localparam logic [X_BITS-1:0] X_LAST = X_BITS'(H_VISIBLE - 1);
  localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(V_VISIBLE - 1);
  localparam logic [X_BITS:0]   X_LIM  = (X_BITS+1)'(H_VISIBLE);
  localparam logic [Y_BITS:0]   Y_LIM  = (Y_BITS+1)'(V_VISIBLE);

  xl_state_e state_q;

  logic [X_BITS-1:0]      x0_q, x1_q;
  logic [Y_BITS-1:0]      y0_q, y1_q;
  logic [PIXEL_WIDTH-1:0] color_q;
  logic                   wr_en_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [PIXEL_WIDTH-1:0] data_q;
  logic                   done_q;

  logic [X_BITS-1:0] xmin, xmax;
  logic [Y_BITS-1:0] ymin, ymax;
  logic              empty;

  logic [X_BITS-1:0] nxt_x;
  logic [Y_BITS-1:0] nxt_y;
  logic              last;
  logic              cnt_load, cnt_step;

  // Order the latched corners and clip to the visible area.
  always_comb begin
    xmin = (x0_q < x1_q) ? x0_q : x1_q;
    xmax = (x0_q < x1_q) ? x1_q : x0_q;
    ymin = (y0_q < y1_q) ? y0_q : y1_q;
    ymax = (y0_q < y1_q) ? y1_q : y0_q;
    if (xmax > X_LAST) xmax = X_LAST;
    if (ymax > Y_LAST) ymax = Y_LAST;
    empty = ({1'b0, xmin} >= X_LIM) ||
            ({1'b0, ymin} >= Y_LIM);
  end

  assign cnt_load = (state_q == ST_SETUP) && !empty;
  assign cnt_step = (state_q == ST_FILL) && !last;

  xl_raster_counter #(
    .X_BITS (X_BITS),
    .Y_BITS (Y_BITS)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .load_i  (cnt_load),
    .step_i  (cnt_step),
    .xmin_i  (xmin),
    .xmax_i  (xmax),
    .ymin_i  (ymin),
    .ymax_i  (ymax),
    .nxt_x_o (nxt_x),
    .nxt_y_o (nxt_y),
    .last_o  (last)
  );

  // Command FSM with registered write-port outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      color_q <= '0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            x0_q    <= cmd_x0;
            y0_q    <= cmd_y0;
            x1_q    <= cmd_x1;
            y1_q    <= cmd_y1;
            color_q <= cmd_color;
            state_q <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (empty) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            wr_en_q <= 1'b1;
            addr_q  <= xl_pack_addr(ymin, xmin);
            data_q  <= color_q;
            state_q <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (last) begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            addr_q <= xl_pack_addr(nxt_y, nxt_x);
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign XL_wr_en   = wr_en_q;
  assign XL_wr_addr = addr_q;
  assign XL_wr_data = data_q;

endmodule

// File: doc/xl_rect_fill.md
Name: xl_rect_fill

Overview:
- Upstream stage of the frame-buffer write arbiter: the accelerator ("XL") side that drives the XL write port.
- Accepts one rectangle-fill command at a time and emits one frame-buffer pixel write per cycle, in raster order.
- The arbiter gives XL writes unconditional priority over CPU writes, so this block never stalls mid-fill.

Parameters:
- PIXEL_WIDTH, 32, width of one frame-buffer word; one pixel per word.
- X_BITS, 10, column coordinate width.
- Y_BITS, 10, row coordinate width.
- H_VISIBLE, 800, visible columns; writes are clipped to 0..H_VISIBLE-1.
- V_VISIBLE, 600, visible rows; writes are clipped to 0..V_VISIBLE-1.
- ADDR_WIDTH, X_BITS+Y_BITS, frame-buffer address width; addr = {y, x}.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_x0  in  X_BITS  first corner column.
- cmd_y0  in  Y_BITS  first corner row.
- cmd_x1  in  X_BITS  second corner column.
- cmd_y1  in  Y_BITS  second corner row.
- cmd_color  in  PIXEL_WIDTH  fill value.
- XL_wr_en  out  1  frame-buffer write strobe.
- XL_wr_addr  out  ADDR_WIDTH  write address {y, x}.
- XL_wr_data  out  PIXEL_WIDTH  write data.
- busy  out  1  a command is in progress.
- done  out  1  one-cycle pulse when a command completes.

Behaviour:
- Handshake:
  - A command is accepted on the rising edge where cmd_valid && cmd_ready.
  - cmd_ready = (state == IDLE); it is combinational from state only.
  - All cmd_* inputs are registered at acceptance; later changes have no effect.
- State machine:
  - IDLE -> SETUP on accept.
  - SETUP -> FILL if the clipped rectangle is non-empty, else -> DONE.
  - FILL -> DONE after the write of the last pixel.
  - DONE -> IDLE unconditionally.
- SETUP (one cycle):
  - xmin = min(x0,x1), xmax = max(x0,x1); same for y. Corners may be given in any order.
  - Clip: xmax = min(xmax, H_VISIBLE-1), ymax = min(ymax, V_VISIBLE-1).
  - The rectangle is empty if xmin >= H_VISIBLE or ymin >= V_VISIBLE.
- FILL:
  - XL_wr_en = 1 every cycle.
  - Address = {cur_y, cur_x}; data = the latched color.
  - Start at (xmin, ymin); increment cur_x each cycle.
  - When cur_x == xmax: cur_x <= xmin and cur_y increments.
  - The last write is at (xmax, ymax).
  - Write count = (xmax-xmin+1)*(ymax-ymin+1), one per cycle, with no bubbles.
- Timing and outputs:
  - Latency: accept at edge T; first XL_wr_en high in cycle T+2 (after IDLE, SETUP).
  - done is high for exactly the one cycle in DONE, i.e. the cycle after the last write. For an empty rectangle, done is high in cycle T+2 and no writes occur.
  - busy = (state != IDLE).
  - XL_wr_en, XL_wr_addr and XL_wr_data are registered outputs. When XL_wr_en = 0, addr and data hold their last values.
- Reset values: state IDLE, XL_wr_en 0, XL_wr_addr 0, XL_wr_data 0, done 0, busy 0, cmd_ready 1 in the first cycle after reset.
- Reset mid-operation:
  - XL_wr_en is 0 in the cycle after the reset edge.
  - The remaining writes are abandoned and no done pulse is issued.
- Width rules:
  - All coordinate compares are unsigned.
  - The cur_x / cur_y counters are X_BITS / Y_BITS wide. Clipping guarantees they never wrap.
- Back-to-back commands: the earliest next accept is the cycle after DONE, i.e. the IDLE cycle. There is no overlap of commands.

Decomposition:
- Shared package / header: state encodings (IDLE, SETUP, FILL, DONE) and an address-pack function {y, x} reused by the arbiter-side frame-buffer logic.
- One natural sub-module: xl_raster_counter. It holds the xmin/xmax/ymin/ymax-bounded 2-D counter with load, step and last outputs. The FSM, clipping and output registers remain in xl_rect_fill.

Test Plan:
- Reset, then cmd (x0=2,y0=3,x1=4,y1=4,color=0xAABBCCDD).
  - Expect 6 writes on consecutive cycles starting at T+2.
  - Addresses {3,2},{3,3},{3,4},{4,2},{4,3},{4,4}, all with data 0xAABBCCDD.
  - done at T+8; cmd_ready high again at T+9.
- Swapped corners (x0=4,y0=4,x1=2,y1=3) -> identical write sequence to the previous scenario.
- Clip: (x0=798,y0=599,x1=900,y1=700) -> exactly 2 writes, {599,798} and {599,799}, then done.
- Off-screen: (x0=850,y0=10,x1=900,y1=20) -> zero writes; done at T+2.
- Single pixel: (5,5,5,5) -> one write at T+2 to {5,5}; done at T+3.
  - cmd_valid held high throughout: the next command is accepted in the IDLE cycle T+4, and no command is accepted while busy.
- Assert rst during FILL of a 10x10 rectangle after 17 writes:
  - XL_wr_en is 0 the next cycle; no done pulse.
  - busy is 0 and cmd_ready is 1 after reset.
